// File: rtl/ppe_pkg.sv
// Shared defaults and state encoding for the PPE round-robin request controller.
package ppe_pkg;

    localparam int PPE_W       = 1024;
    localparam int PPE_LOG_W   = 10;
    localparam int PPE_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        OFFER
    } state_e;

endpackage

// File: rtl/ppe_idx_decoder.sv
// Combinational index-to-one-hot decoder; all zeros when disabled.
module ppe_idx_decoder #(
    parameter int W     = 1024,
    parameter int LOG_W = 10
) (
    input  logic             en_i,
    input  logic [LOG_W-1:0] idx_i,
    output logic [W-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/ppe_rr_scheduler.sv
// Round-robin request controller around an external programmable priority encoder.
// One grant per round (3+PPE_LAT cycles); a grant is held until gnt_ready.
module ppe_rr_scheduler
    import ppe_pkg::*;
#(
    parameter int W       = PPE_W,
    parameter int LOG_W   = PPE_LOG_W,
    parameter int PPE_LAT = PPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_vld,
    input  logic [LOG_W-1:0] set_idx,
    output logic [W-1:0]     ppe_req,
    output logic [LOG_W-1:0] ppe_p_enc,
    input  logic [LOG_W-1:0] ppe_value,
    input  logic [LOG_W-1:0] ppe_value_inc,
    input  logic             ppe_valid,
    output logic             gnt_valid,
    output logic [LOG_W-1:0] gnt_idx,
    output logic [W-1:0]     gnt_onehot,
    input  logic             gnt_ready,
    output logic             pend_empty,
    output logic             err
);

    localparam int CNT_W = ($clog2(PPE_LAT + 1) < 1) ? 1 : $clog2(PPE_LAT + 1);

    state_e           state_q, state_d;
    logic [W-1:0]     pend_q, pend_d;
    logic [W-1:0]     snap_q, snap_d;
    logic [LOG_W-1:0] ptr_q, ptr_d;
    logic [LOG_W-1:0] nxt_ptr_q, nxt_ptr_d;
    logic [LOG_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             pend_empty_q;
    logic             hs;

    assign hs = (state_q == OFFER) && gnt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            snap_q       <= '0;
            ptr_q        <= '0;
            nxt_ptr_q    <= '0;
            gnt_idx_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            pend_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            snap_q       <= snap_d;
            ptr_q        <= ptr_d;
            nxt_ptr_q    <= nxt_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            pend_empty_q <= (pend_d == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pend_q != '0) state_d = LOOKUP;
            LOOKUP:  if (cnt_q == '0) state_d = ppe_valid ? OFFER : IDLE;
            OFFER:   if (gnt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d    = pend_q;
        snap_d    = snap_q;
        ptr_d     = ptr_q;
        nxt_ptr_d = nxt_ptr_q;
        gnt_idx_d = gnt_idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        // Set is applied after the grant clear so a same-cycle re-request survives.
        if (hs) begin
            pend_d[gnt_idx_q] = 1'b0;
        end
        if (set_vld) begin
            pend_d[set_idx] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    snap_d = pend_q;
                    cnt_d  = CNT_W'(PPE_LAT);
                end
            end
            LOOKUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (ppe_valid) begin
                    gnt_idx_d = ppe_value;
                    nxt_ptr_d = ppe_value_inc;
                end else begin
                    err_d = 1'b1;
                end
            end
            OFFER: begin
                if (gnt_ready) begin
                    ptr_d = nxt_ptr_q;
                end
            end
            default: ;
        endcase
    end

    assign ppe_req    = snap_q;
    assign ppe_p_enc  = ptr_q;
    assign gnt_valid  = (state_q == OFFER);
    assign gnt_idx    = gnt_idx_q;
    assign pend_empty = pend_empty_q;
    assign err        = err_q;

    ppe_idx_decoder #(
        .W     (W),
        .LOG_W (LOG_W)
    ) u_dec (
        .en_i     (gnt_valid),
        .idx_i    (gnt_idx_q),
        .onehot_o (gnt_onehot)
    );

endmodule

// File: tb/tb_ppe_rr_scheduler.sv
// Bench for ppe_rr_scheduler: behavioural encoder beside the DUT, round-level scoreboard model.
module tb_ppe_rr_scheduler;

    localparam int W       = 1024;
    localparam int LOG_W   = 10;
    localparam int PPE_LAT = 1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             set_vld   = 1'b0;
    logic [LOG_W-1:0] set_idx   = '0;
    logic             gnt_ready = 1'b0;
    logic [W-1:0]     ppe_req;
    logic [LOG_W-1:0] ppe_p_enc;
    logic [LOG_W-1:0] enc_value;
    logic [LOG_W-1:0] enc_inc;
    logic             enc_valid;
    logic             gnt_valid;
    logic [LOG_W-1:0] gnt_idx;
    logic [W-1:0]     gnt_onehot;
    logic             pend_empty;
    logic             err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    ppe_rr_scheduler #(
        .W       (W),
        .LOG_W   (LOG_W),
        .PPE_LAT (PPE_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .set_vld       (set_vld),
        .set_idx       (set_idx),
        .ppe_req       (ppe_req),
        .ppe_p_enc     (ppe_p_enc),
        .ppe_value     (enc_value),
        .ppe_value_inc (enc_inc),
        .ppe_valid     (enc_valid),
        .gnt_valid     (gnt_valid),
        .gnt_idx       (gnt_idx),
        .gnt_onehot    (gnt_onehot),
        .gnt_ready     (gnt_ready),
        .pend_empty    (pend_empty),
        .err           (err)
    );

    // First set index at or after start, wrapping; -1 when none.
    function automatic int find_from(input logic [W-1:0] v, input int start);
        for (int k = 0; k < W; k++) begin
            int j;
            j = (start + k) % W;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Encoder with one cycle of latency; enc_break forces valid low.
    logic enc_break = 1'b0;
    always @(posedge clk) begin : enc_model
        int f;
        f = find_from(ppe_req, int'(ppe_p_enc));
        enc_valid <= (f >= 0) && !enc_break;
        enc_value <= (f >= 0) ? LOG_W'(f) : '0;
        enc_inc   <= (f >= 0) ? LOG_W'((f + 1) % W) : '0;
    end

    // Round-level reference model and monitor
    typedef struct {
        int idx;
        int due;
    } exp_t;

    exp_t         expq[$];
    int           glog[$];
    logic [W-1:0] m_pend  = '0;
    int           m_ptr   = 0;
    bit           m_busy  = 1'b0;
    bit           model_en = 1'b1;
    logic [W-1:0] oh_exp;
    int           hidx;

    always @(negedge clk) begin : monitor
        if (model_en) begin
            if (rst) begin
                m_pend = '0;
                m_ptr  = 0;
                m_busy = 1'b0;
                expq.delete();
            end else begin
                chk("pend_empty", int'(pend_empty), int'(m_pend == '0));
                chk("ppe_p_enc", int'(ppe_p_enc), m_ptr);
                chk("err_clear", int'(err), 0);
                oh_exp = '0;
                if (gnt_valid) oh_exp[gnt_idx] = 1'b1;
                chk("gnt_onehot", int'(gnt_onehot == oh_exp), 1);

                if (expq.size() > 0 && cyc == expq[0].due)
                    chk("gnt_latency", int'(gnt_valid), 1);
                if (gnt_valid && (expq.size() == 0 || cyc < expq[0].due))
                    chk("unexpected_grant", int'(gnt_valid), 0);

                // A round starts in an idle cycle with anything pending.
                if (!m_busy && m_pend != '0) begin
                    expq.push_back('{idx: find_from(m_pend, m_ptr), due: cyc + 2 + PPE_LAT});
                    m_busy = 1'b1;
                end

                if (gnt_valid && gnt_ready && expq.size() > 0 && cyc >= expq[0].due) begin
                    hidx = expq[0].idx;
                    chk("gnt_idx", int'(gnt_idx), hidx);
                    glog.push_back(int'(gnt_idx));
                    void'(expq.pop_front());
                    m_pend[hidx] = 1'b0;
                    m_ptr  = (hidx + 1) % W;
                    m_busy = 1'b0;
                end

                if (set_vld) m_pend[set_idx] = 1'b1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx);
        set_vld = 1'b1;
        set_idx = LOG_W'(idx);
        tick();
        set_vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(expq.size() == 0 && m_pend == '0 && !m_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(n < budget), 1);
    endtask

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        while (!gnt_valid && n < 50) begin
            tick();
            n++;
        end
        chk(name, int'(gnt_valid), 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0;
        int bad;
        bit gv_seen;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_gnt_valid", int'(gnt_valid), 0);
        chk("rst_gnt_idx", int'(gnt_idx), 0);
        chk("rst_onehot", int'(gnt_onehot == '0), 1);
        chk("rst_pend_empty", int'(pend_empty), 1);
        chk("rst_err", int'(err), 0);
        chk("rst_ppe_req", int'(ppe_req == '0), 1);
        chk("rst_p_enc", int'(ppe_p_enc), 0);

        // Ordering
        gnt_ready = 1'b1;
        glog.delete();
        set_req(3);
        set_req(5);
        set_req(8);
        wait_idle(100);
        chk("order_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("order_0", glog[0], 3);
            chk("order_1", glog[1], 5);
            chk("order_2", glog[2], 8);
        end
        chk("order_ptr", int'(ppe_p_enc), 9);
        chk("order_empty", int'(pend_empty), 1);

        // Wrap-around
        glog.delete();
        set_req(2);
        wait_idle(100);
        chk("wrap_ptr3", int'(ppe_p_enc), 3);
        set_req(1023);
        set_req(1);
        n0 = 0;
        while (glog.size() < 2 && n0 < 100) begin
            tick();
            n0++;
        end
        chk("wrap_ptr0", int'(ppe_p_enc), 0);
        wait_idle(100);
        chk("wrap_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("wrap_g1", glog[1], 1023);
            chk("wrap_g2", glog[2], 1);
        end

        // Backpressure
        glog.delete();
        gnt_ready = 1'b0;
        set_req(7);
        wait_gnt("bp_valid_rise");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", int'(gnt_valid), 1);
            chk("bp_hold_idx", int'(gnt_idx), 7);
            chk("bp_hold_onehot", int'(gnt_onehot[7]), 1);
            chk("bp_pending", int'(pend_empty), 0);
            tick();
        end
        gnt_ready = 1'b1;
        wait_idle(100);
        chk("bp_one_grant", glog.size(), 1);

        // Set/clear collision
        glog.delete();
        set_req(4);
        wait_gnt("coll_valid_rise");
        set_vld = 1'b1;
        set_idx = LOG_W'(4);
        tick();
        set_vld = 1'b0;
        chk("coll_still_pending", int'(pend_empty), 0);
        wait_idle(100);
        chk("coll_count", glog.size(), 2);
        if (glog.size() == 2) chk("coll_regrant", glog[1], 4);

        // Full load
        pulse_rst();
        glog.delete();
        for (int i = 0; i < W; i++) set_req(i);
        wait_idle(8000);
        chk("full_count", glog.size(), W);
        bad = 0;
        for (int i = 0; i < glog.size(); i++) if (glog[i] != i) bad++;
        chk("full_order_errors", bad, 0);
        chk("full_err", int'(err), 0);
        chk("full_empty", int'(pend_empty), 1);

        // Reset mid-offer
        set_req(5);
        wait_idle(100);
        gnt_ready = 1'b0;
        set_req(12);
        wait_gnt("rstoff_valid_rise");
        chk("rstoff_idx", int'(gnt_idx), 12);
        pulse_rst();
        chk("rstoff_gnt_valid", int'(gnt_valid), 0);
        chk("rstoff_ppe_req", int'(ppe_req == '0), 1);
        chk("rstoff_p_enc", int'(ppe_p_enc), 0);
        chk("rstoff_empty", int'(pend_empty), 1);
        gnt_ready = 1'b1;
        n0 = glog.size();
        gv_seen = 1'b0;
        repeat (20) begin
            tick();
            if (gnt_valid) gv_seen = 1'b1;
        end
        chk("rstoff_no_grant", int'(gv_seen), 0);
        chk("rstoff_no_log", glog.size(), n0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            set_vld   = ($urandom_range(0, 4) == 0);
            set_idx   = ($urandom_range(0, 1) == 0) ? LOG_W'($urandom_range(0, 15))
                                                    : LOG_W'($urandom_range(0, W - 1));
            gnt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        set_vld   = 1'b0;
        gnt_ready = 1'b1;
        wait_idle(20000);

        // Encoder reporting no valid on a non-empty snapshot
        model_en  = 1'b0;
        enc_break = 1'b1;
        set_req(20);
        gv_seen = 1'b0;
        repeat (15) begin
            tick();
            if (gnt_valid) gv_seen = 1'b1;
        end
        chk("err_sticky", int'(err), 1);
        chk("err_no_grant", int'(gv_seen), 0);
        chk("err_pending", int'(pend_empty), 0);
        pulse_rst();
        chk("err_rst_clear", int'(err), 0);
        enc_break = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ppe_rr_scheduler.md
Name: ppe_rr_scheduler

Overview:
- Request-side controller for the programmable priority encoder (ppe_w1024_p). It holds a pending-request bitmap and drives the encoder's Req and P_enc inputs.
- It consumes the encoder's o_value, o_value_inc and valid outputs, and issues one grant per round over a valid/ready handshake.
- After each accepted grant it clears the granted bit and advances the pointer to o_value_inc. The result is work-conserving round-robin arbitration across W requesters.

Parameters:
W, 1024, number of requesters; must equal the encoder width.
LOG_W, 10, index width, clog2(W).
PPE_LAT, 1, cycles from ppe_req/ppe_p_enc stable to ppe_* outputs valid; 0 means a combinational encoder.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
set_vld  in  1  request-set strobe.
set_idx  in  LOG_W  index to mark pending.
ppe_req  out  W  to encoder Req; snapshot of the pending bitmap.
ppe_p_enc  out  LOG_W  to encoder P_enc; current round-robin pointer.
ppe_value  in  LOG_W  from encoder o_value.
ppe_value_inc  in  LOG_W  from encoder o_value_inc, equal to (o_value+1) mod W.
ppe_valid  in  1  from encoder valid.
gnt_valid  out  1  grant offered.
gnt_idx  out  LOG_W  granted index.
gnt_onehot  out  W  decoded grant, equal to 1<<gnt_idx when gnt_valid=1, else 0.
gnt_ready  in  1  consumer accepts the grant.
pend_empty  out  1  pending bitmap is zero.
err  out  1  sticky: encoder reported valid=0 on a non-empty snapshot.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pend=0, snap=0, ptr=0, state=IDLE.
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, pend_empty=1, err=0.
  - set_vld is ignored while rst=1.
  - Reset takes effect from any state, including mid-LOOKUP or mid-OFFER; no grant survives it.
- Contract of the encoder:
  - valid=1 iff Req≠0.
  - o_value is the lowest set index ≥ P_enc if one exists, else the lowest set index overall.
- Pending bitmap:
  - set_vld sets pend[set_idx] at the next edge, in any state.
  - Setting an already-pending bit has no effect.
  - If the same index is set and cleared by a grant in the same cycle, set wins and the bit stays pending.
  - pend_empty is registered, i.e. (pend==0) as of the current cycle.
- State machine:
  - IDLE: if pend≠0, then snap<=pend, cnt<=PPE_LAT, go to LOOKUP.
  - LOOKUP: hold ppe_req=snap and ppe_p_enc=ptr stable.
    - While cnt>0, decrement cnt.
    - At cnt==0, sample the ppe_* outputs.
    - If ppe_valid=1: gnt_idx<=ppe_value, latch nxt_ptr<=ppe_value_inc, go to OFFER.
    - If ppe_valid=0: set err, go to IDLE.
  - OFFER: gnt_valid=1; gnt_idx and gnt_onehot are held stable until the handshake.
    - On gnt_valid&&gnt_ready: clear pend[gnt_idx] (subject to set-wins), ptr<=nxt_ptr, go to IDLE.
    - gnt_valid falls in the following cycle.
- Timing:
  - Requests set after the snapshot is taken are not seen until the next round.
  - Latency from set_vld in cycle t (empty, IDLE) to gnt_valid is t+3+PPE_LAT; with PPE_LAT=1 that is t+4.
  - Back-to-back throughput is one grant per 3+PPE_LAT cycles with gnt_ready held high.
- Pointer and widths:
  - The pointer wraps: a grant at W-1 gives ptr=0, taken directly from ppe_value_inc.
  - No internal addition is performed on the pointer.
  - cnt is clog2(PPE_LAT+1) bits wide, minimum 1.
- ppe_req and ppe_p_enc are registered outputs and change only on an IDLE->LOOKUP transition or an accepted grant.

Decomposition:
- Shared package ppe_pkg holds:
  - W and LOG_W defaults;
  - the state enum {IDLE, LOOKUP, OFFER};
  - the PPE_LAT default matching ppe_w1024_p.
- One sub-module, ppe_idx_decoder: combinational LOG_W->W one-hot decoder with an enable, driving gnt_onehot.
- The encoder itself is instantiated beside this block at the next level up, not inside it.

Test Plan:
1. Ordering: ptr=0, set 3, 5, 8 in consecutive cycles, gnt_ready=1 → grants 3, 5, 8 in order; ptr=9 afterwards; pend_empty=1.
2. Wrap-around: set 2 → grant 2, ptr=3; then set 1023 and 1 → grant 1023, ptr=0; then grant 1; ppe_p_enc observed as 3, then 0.
3. Backpressure: a single request at 7 with gnt_ready=0 for 5 cycles → gnt_valid held 1; gnt_idx=7 and gnt_onehot bit 7 stable; pend[7]=1; on ready, exactly one grant.
4. Set/clear collision: during the OFFER of idx 4, set_vld with idx=4 in the handshake cycle → pend[4] remains 1; idx 4 is granted again in the next round.
5. Full load: all 1024 bits set, gnt_ready=1 → exactly 1024 grants, indices 0..1023 each once in ascending order; then IDLE, pend_empty=1, err=0.
6. Reset mid-OFFER: assert rst for 1 cycle while gnt_valid=1 with idx 12 → next cycle gnt_valid=0, ppe_req=0, ptr=0, pend_empty=1; no grant thereafter until a new set.
